// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out path.
package vga_pkg;
    localparam int PIX_W        = 24;
    localparam int R_LSB        = 16;
    localparam int G_LSB        = 8;
    localparam int B_LSB        = 0;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FLUSH
    } rd_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; writer guarantees it never overfills.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          pop_ok;

    assign empty  = (level == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rp];

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr)     wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            case ({wr, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/vga_frame_reader.sv
// Burst-fetches frame pixels from memory into a FIFO and serves them to the
// VGA controller; a Vsync fall realigns the fetch pointer to the frame base.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = FRAME_PIXELS,
    parameter int                BURST_LEN   = 8,
    parameter int                FIFO_DEPTH  = 16,
    localparam int               LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clock25,
    input  logic              Reset,
    input  logic              Vsync,
    input  logic              read_en,
    output logic [PIX_W-1:0]  Data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underflow
);
    localparam int                BW        = $clog2(BURST_LEN + 1);
    localparam logic [LVL_W-1:0]  SPACE     = LVL_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W:0]   BURST_INC = (ADDR_W+1)'(BURST_LEN);

    rd_state_t         state;
    logic              vsync_q;
    logic              pend;
    logic [BW-1:0]     beat_cnt;
    logic [ADDR_W-1:0] word_ptr;
    logic [ADDR_W:0]   ptr_sum;
    logic              restart, last_beat;
    logic              fifo_wr, fifo_pop, fifo_flush, fifo_empty;
    pixel_t            fifo_head;

    assign restart    = vsync_q && !Vsync;
    assign last_beat  = pend && mem_rvalid && (beat_cnt == LAST_BEAT);
    assign ptr_sum    = {1'b0, word_ptr} + BURST_INC;
    // The beat that coincides with the Vsync fall already belongs to the old frame.
    assign fifo_wr    = mem_rvalid && (state == WAIT_DATA) && !restart;
    assign fifo_pop   = read_en && (state != FLUSH) && !fifo_empty;
    assign fifo_flush = (state == FLUSH) && !pend;

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (PIX_W)
    ) u_fifo (
        .clk  (Clock25),
        .rst_n(Reset),
        .wr   (fifo_wr),
        .wdata(mem_rdata),
        .pop  (fifo_pop),
        .flush(fifo_flush),
        .head (fifo_head),
        .level(fifo_level),
        .empty(fifo_empty)
    );

    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= BASE_ADDR;
            word_ptr <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
            vsync_q  <= 1'b1;
        end else begin
            vsync_q <= Vsync;
            // Beats of a granted burst are counted in WAIT_DATA and FLUSH alike.
            if (pend && mem_rvalid) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (last_beat) pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (restart) begin
                        state <= FLUSH;
                    end else if (fifo_level <= SPACE) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= BASE_ADDR + word_ptr;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        pend     <= 1'b1;
                        beat_cnt <= '0;
                        state    <= restart ? FLUSH : WAIT_DATA;
                    end else if (restart) begin
                        mem_req <= 1'b0;
                        state   <= FLUSH;
                    end
                end
                WAIT_DATA: begin
                    if (restart) begin
                        state <= FLUSH;
                    end else if (last_beat) begin
                        state    <= IDLE;
                        word_ptr <= (ptr_sum == FRAME_END) ? '0 : ptr_sum[ADDR_W-1:0];
                    end
                end
                FLUSH: begin
                    if (!pend) begin
                        word_ptr <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock25 or negedge Reset) begin
        if (!Reset) begin
            Data      <= '0;
            underflow <= 1'b0;
        end else begin
            if (fifo_pop)              Data      <= fifo_head;
            if (read_en && fifo_empty) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with a memory model and a queue-based pixel model.
module tb_vga_frame_reader;
    localparam int B  = 8;
    localparam int D  = 16;
    localparam int FW = 32;

    logic        Clock25 = 1'b0;
    logic        Reset = 1'b0, Vsync = 1'b1, read_en = 1'b0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [23:0] mem_rdata = '0;
    logic [23:0] Data;
    logic        mem_req, underflow;
    logic [18:0] mem_addr;
    logic [4:0]  fifo_level;

    vga_frame_reader #(
        .ADDR_W(19), .BASE_ADDR(19'd0), .FRAME_WORDS(FW), .BURST_LEN(B), .FIFO_DEPTH(D)
    ) dut (
        .Clock25(Clock25), .Reset(Reset), .Vsync(Vsync), .read_en(read_en), .Data(Data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .underflow(underflow)
    );

    always #20 Clock25 = ~Clock25;

    int ntests = 0, nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        ntests++;
        nfail++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // memory model controls and state
    int          gnt_delay = 0;
    bit          stall = 0;
    int          gwait = 0, left = 0, beat_idx = 0;
    bit          busy = 0;
    logic [23:0] seq = 24'd1;
    int          gaddr[$];

    // samples taken at the active edge
    logic        s_rst, s_vs, s_re, s_gnt, s_rv;
    logic [23:0] s_rd;
    always @(posedge Clock25) begin
        s_rst = Reset; s_vs = Vsync; s_re = read_en;
        s_gnt = mem_gnt; s_rv = mem_rvalid; s_rd = mem_rdata;
    end

    // pixel model
    logic [23:0] q[$];
    logic [23:0] m_data = '0;
    bit          m_uf = 0, m_vprev = 1, m_disc = 0, fall;
    int          m_left = 0, m_win = 0, m_addr = 0;

    always @(negedge Clock25) begin
        if (!s_rst || !Reset) begin
            q.delete(); m_data = '0; m_uf = 0; m_vprev = 1; m_disc = 0;
            m_left = 0; m_win = 0; m_addr = 0;
            mem_gnt = 0; mem_rvalid = 0; busy = 0; left = 0; beat_idx = 0;
            gwait = gnt_delay; seq = 24'd1;
            chk("rst_data", Data, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_level", fifo_level, 0);
            chk("rst_uf", underflow, 0);
        end else begin
            fall = m_vprev && !s_vs;
            m_vprev = s_vs;
            if (s_re) begin
                if (q.size() > 0) m_data = q.pop_front();
                else m_uf = 1;
            end
            if (s_gnt) begin
                m_left = B;
                m_addr = (m_addr + B) % FW;
            end
            if (s_rv && m_left > 0) begin
                m_left--;
                if (m_disc || fall) m_win = 2;
                else q.push_back(s_rd);
                if (m_left == 0) m_disc = 0;
            end
            if (fall) begin
                q.delete();
                m_addr = 0;
                m_disc = (m_left > 0);
                m_win = 2;
            end
            if (m_win > 0) m_win--;

            chk("data", Data, m_data);
            chk("underflow", underflow, m_uf);
            if (mem_req) chk("mem_addr", mem_addr, m_addr);
            if (!m_disc && m_win == 0) chk("fifo_level", fifo_level, q.size());

            mem_gnt = 0; mem_rvalid = 0; beat_idx = 0;
            if (busy) begin
                if (!stall) begin
                    mem_rvalid = 1; mem_rdata = seq; seq++;
                    beat_idx = B - left + 1; left--;
                    if (left == 0) busy = 0;
                end
            end else if (mem_req && !stall) begin
                if (gwait == 0) begin
                    mem_gnt = 1; busy = 1; left = B;
                    gaddr.push_back(int'(mem_addr));
                    gwait = gnt_delay;
                end else gwait--;
            end else gwait = gnt_delay;
        end
    end

    task automatic wait_req_rise(input string name);
        bit   ok = 0;
        logic prev = mem_req;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock25);
            if (mem_req && !prev) ok = 1;
            prev = mem_req;
        end
        if (!ok) bad(name);
    endtask

    task automatic wait_level(input int n, input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clock25);
            if (fifo_level == n) ok = 1;
        end
        if (!ok) bad(name);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock25); #2 read_en = 1;
        end
        @(posedge Clock25); #2 read_en = 0;
        @(negedge Clock25);
    endtask

    initial begin
        int          npops, idx, lvl, n0;
        bit          ok;
        logic [23:0] v3;
        v3 = '0;
        repeat (3) @(posedge Clock25);
        @(negedge Clock25);
        chk("reset_addr", mem_addr, 0);
        @(posedge Clock25); #2 Reset = 1;

        // first two bursts from reset
        wait_req_rise("first_req");
        chk("first_addr", mem_addr, 0);
        wait_req_rise("second_req");
        chk("second_addr", mem_addr, 8);
        chk("level_at_2nd_req", fifo_level, 8);
        wait_level(16, "fill16");
        pops(1); chk("pop1", Data, 24'h000001);
        pops(1); chk("pop2", Data, 24'h000002);
        pops(1); chk("pop3", Data, 24'h000003);

        // steady scan-out at 3 pops per 4 cycles
        npops = 0;
        for (int i = 0; i < 1336; i++) begin
            @(posedge Clock25); #2 read_en = (i % 4 != 3);
            if (i % 4 != 3) npops++;
        end
        @(posedge Clock25); #2 read_en = 0;
        @(negedge Clock25);
        chk("steady_uf", underflow, 0);
        chk("steady_last", Data, 3 + npops);
        repeat (40) @(negedge Clock25);

        // delayed grant: exactly one burst
        gnt_delay = 5;
        lvl = int'(fifo_level);
        n0 = gaddr.size();
        if (lvl > 8) pops(lvl - 8);
        repeat (60) @(negedge Clock25);
        chk("one_burst", gaddr.size() - n0, 1);
        chk("level_after_delay", fifo_level, 16);
        gnt_delay = 0;

        // frame wrap of a 32-word frame
        idx = -1;
        foreach (gaddr[k]) if (idx < 0 && gaddr[k] == 24 && k + 1 < gaddr.size()) idx = k;
        if (idx < 0) bad("wrap_seen");
        else chk("wrap_addr", gaddr[idx+1], 0);

        // Vsync fall right after beat 3 of a burst
        pops(8);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge Clock25);
            if (mem_rvalid && beat_idx == 3) begin ok = 1; v3 = mem_rdata; end
        end
        if (!ok) bad("beat3");
        #2 Vsync = 0;
        wait_req_rise("restart_req");
        chk("restart_addr", mem_addr, 0);
        chk("restart_level", fifo_level, 0);
        @(posedge Clock25); #2 Vsync = 1;
        wait_level(16, "refill16");
        pops(1);
        chk("post_restart_data", Data, v3 + 24'd6);

        // stalled memory then pop on empty
        stall = 1;
        pops(16);
        chk("uf_set", underflow, 1);
        chk("uf_hold", Data, v3 + 24'd21);
        @(posedge Clock25); #2 Reset = 0;
        @(negedge Clock25);
        chk("uf_cleared", underflow, 0);
        chk("data_cleared", Data, 0);
        stall = 0;
        @(posedge Clock25); #2 Reset = 1;
        repeat (20) @(negedge Clock25);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
